// File: rtl/key_debounce.sv
// Debounced reader for active-low pushbuttons. Each channel synchronises its raw
// pin, filters it through a four-state debounce FSM and reports a stable pressed
// level plus one-cycle press, release and long-press pulses.
module key_debounce #(
  parameter int unsigned NUM_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  // Wide enough to hold the saturation value one above the long-press threshold.
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldSat  = HoldW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StPressed,
    StReleaseDb
  } state_e;

  logic [NUM_KEYS-1:0] sync_q;
  logic [NUM_KEYS-1:0] ks_q;

  // Two-flop synchroniser; resets to the released level so nothing fires on reset exit.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync_q <= '1;
      ks_q   <= '1;
    end else begin
      sync_q <= key;
      ks_q   <= sync_q;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    state_e            state_q, state_d;
    logic [DbW-1:0]    db_q, db_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
        state_q   <= StIdle;
        db_q      <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        db_q      <= db_d;
        hold_q    <= hold_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    // Debounce FSM: next state, counter updates and event pulses.
    always_comb begin
      state_d   = state_q;
      db_d      = db_q;
      hold_d    = hold_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!ks_q[i]) begin
            state_d = StPressDb;
            db_d    = '0;
          end
        end
        StPressDb: begin
          if (ks_q[i]) begin
            state_d = StIdle;
          end else if (db_q == DbLast) begin
            state_d = StPressed;
            press_d = 1'b1;
            level_d = 1'b1;
            hold_d  = '0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
        StPressed: begin
          if (ks_q[i]) begin
            state_d = StReleaseDb;
            db_d    = '0;
          end else if (hold_q < HoldLast) begin
            hold_d = hold_q + 1'b1;
          end else if (hold_q == HoldLast) begin
            // Park one above the threshold so the long pulse fires only once.
            long_d = 1'b1;
            hold_d = HoldSat;
          end
        end
        StReleaseDb: begin
          // Hold counter is left untouched here so a rejected release resumes timing.
          if (!ks_q[i]) begin
            state_d = StPressed;
          end else if (db_q == DbLast) begin
            state_d   = StIdle;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    assign key_state[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule
